// File: rtl/program_loader_if.sv
// Byte-stream port feeding the program loader: in_byte moves only in a cycle
// where in_valid && in_ready; the sender must hold in_byte steady while in_valid waits on in_ready.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Assembles a length-prefixed byte stream into 16-bit instruction-memory writes
// and holds the CPU in reset until a complete program has been loaded.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter logic [15:0] MAX_WORDS = 16'd1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    program_loader_if.slave        s,
    output logic                   write_enable_fm,
    output logic [31:0]            write_addr_fm,
    output logic [15:0]            write_data_fm,
    output logic                   cpu_reset,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            words_loaded,
    output logic [3:0]             state_dbg
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        DATA_HI = 4'd3,
        DATA_LO = 4'd4,
        WRITE   = 4'd5,
        DONE    = 4'd6,
        ERR     = 4'd7
    } state_t;

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [7:0]  hi_q;
    logic        xfer;
    logic [15:0] len_full;
    logic [15:0] idx_next;

    assign xfer      = s.in_valid && s.in_ready;
    assign len_full  = {len_q[15:8], s.in_byte};
    assign idx_next  = idx_q + 16'd1;
    assign state_dbg = state;

    // All outputs are registered; in_ready is set alongside the transition into each load state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            s.in_ready      <= 1'b0;
            write_enable_fm <= 1'b0;
            write_addr_fm   <= 32'd0;
            write_data_fm   <= 16'd0;
            cpu_reset       <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            words_loaded    <= 16'd0;
            len_q           <= 16'd0;
            idx_q           <= 16'd0;
            hi_q            <= 8'd0;
        end else begin
            write_enable_fm <= 1'b0;
            done            <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= LEN_HI;
                        s.in_ready   <= 1'b1;
                        busy         <= 1'b1;
                        err          <= 1'b0;
                        words_loaded <= 16'd0;
                        cpu_reset    <= 1'b1;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= s.in_byte;
                        state       <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_full;
                        idx_q <= 16'd0;
                        if (len_full == 16'd0) begin
                            state      <= DONE;
                            s.in_ready <= 1'b0;
                            done       <= 1'b1;
                        end else if (len_full > MAX_WORDS) begin
                            state      <= ERR;
                            s.in_ready <= 1'b0;
                        end else begin
                            state <= DATA_HI;
                        end
                    end
                end
                DATA_HI: begin
                    if (xfer) begin
                        hi_q  <= s.in_byte;
                        state <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        state           <= WRITE;
                        s.in_ready      <= 1'b0;
                        write_enable_fm <= 1'b1;
                        write_addr_fm   <= BASE_ADDR + {16'd0, idx_q};
                        write_data_fm   <= {hi_q, s.in_byte};
                    end
                end
                WRITE: begin
                    words_loaded <= idx_next;
                    if (idx_next == len_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx_q      <= idx_next;
                        state      <= DATA_HI;
                        s.in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    cpu_reset <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                ERR: begin
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    s.in_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (default base and base 0x100)
// driven one at a time; writes are captured and compared against expected queues.
module tb_program_loader;
    logic clk = 1'b0;
    logic rst;
    logic start0, start1;

    program_loader_if if0();
    program_loader_if if1();

    logic        we0, we1, cpu0, cpu1, busy0, busy1, done0, done1, err0, err1;
    logic [31:0] addr0, addr1;
    logic [15:0] data0, data1, wl0, wl1;
    logic [3:0]  st0, st1;

    program_loader u0 (
        .clk(clk), .reset(rst), .start(start0), .s(if0.slave),
        .write_enable_fm(we0), .write_addr_fm(addr0), .write_data_fm(data0),
        .cpu_reset(cpu0), .busy(busy0), .done(done0), .err(err0),
        .words_loaded(wl0), .state_dbg(st0)
    );

    program_loader #(.BASE_ADDR(32'h100), .MAX_WORDS(16'd1024)) u1 (
        .clk(clk), .reset(rst), .start(start1), .s(if1.slave),
        .write_enable_fm(we1), .write_addr_fm(addr1), .write_data_fm(data1),
        .cpu_reset(cpu1), .busy(busy1), .done(done1), .err(err1),
        .words_loaded(wl1), .state_dbg(st1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int sel = 0;
    int done_cnt = 0;
    logic [47:0] exp_q[$];
    logic [47:0] obs_q[$];

    always @(negedge clk) begin
        if (we0) obs_q.push_back({addr0, data0});
        if (we1) obs_q.push_back({addr1, data1});
        if (done0 || done1) done_cnt++;
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic rdy();
        return (sel == 0) ? if0.in_ready : if1.in_ready;
    endfunction

    task automatic set_in(input logic v, input logic [7:0] b);
        if (sel == 0) begin
            if0.in_valid = v;
            if0.in_byte  = b;
        end else begin
            if1.in_valid = v;
            if1.in_byte  = b;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel == 0) start0 = 1'b1;
        else          start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) begin
            @(negedge clk);
            set_in(1'b0, 8'hEE);
        end
        @(negedge clk);
        set_in(1'b1, b);
        while (rdy() == 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) check("ready_timeout", {47'd0, rdy()}, 48'd1);
        @(posedge clk);
        #1;
        set_in(1'b0, 8'h00);
    endtask

    task automatic wait_done(input string tag, input int exp_cnt);
        int n;
        n = 0;
        while (done_cnt < exp_cnt && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, done_cnt, exp_cnt);
    endtask

    task automatic check_writes(input string tag);
        logic [47:0] e, o;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check(tag, o, e);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, if0.in_ready, 0);
        check({tag, "_we"}, we0, 0);
        check({tag, "_addr"}, addr0, 0);
        check({tag, "_data"}, data0, 0);
        check({tag, "_cpu_reset"}, cpu0, 1);
        check({tag, "_busy"}, busy0, 0);
        check({tag, "_done"}, done0, 0);
        check({tag, "_err"}, err0, 0);
        check({tag, "_words"}, wl0, 0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        if0.in_valid = 1'b0;
        if0.in_byte  = 8'h00;
        if1.in_valid = 1'b0;
        if1.in_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b0;

        // 1) two-word load
        sel = 0;
        pulse_start();
        check("t1_busy", busy0, 1);
        check("t1_cpu_hold", cpu0, 1);
        check("t1_ready", if0.in_ready, 1);
        exp_q.push_back({32'd0, 16'h1234});
        exp_q.push_back({32'd1, 16'hABCD});
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        wait_done("t1_done", 1);
        check_writes("t1_wr");
        check("t1_cpu_rel", cpu0, 0);
        check("t1_words", wl0, 2);
        check("t1_busy_end", busy0, 0);
        check("t1_done_low", done0, 0);

        // 2) base 0x100, one word, gapped valid
        sel = 1;
        pulse_start();
        exp_q.push_back({32'h100, 16'h00FF});
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        send_byte(8'hFF, 1);
        wait_done("t2_done", 2);
        check_writes("t2_wr");
        check("t2_cpu_rel", cpu1, 0);
        check("t2_words", wl1, 1);

        // 3) zero-length program
        sel = 0;
        pulse_start();
        check("t3_cpu_reassert", cpu0, 1);
        check("t3_words_clr", wl0, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        wait_done("t3_done", 3);
        check_writes("t3_wr");
        check("t3_cpu_rel", cpu0, 0);
        check("t3_words", wl0, 0);

        // 4) length 1025 is rejected; err sticky until next start
        pulse_start();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        repeat (3) @(negedge clk);
        check("t4_err", err0, 1);
        check("t4_cpu_hold", cpu0, 1);
        check("t4_busy", busy0, 0);
        check("t4_no_done", done_cnt, 3);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", err0, 1);
        check_writes("t4_wr");
        pulse_start();
        check("t4_err_clr", err0, 0);
        check("t4_busy_again", busy0, 1);
        exp_q.push_back({32'd0, 16'h0007});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        wait_done("t4_done", 4);
        check_writes("t4_wr2");
        check("t4_err_end", err0, 0);

        // 5) reset after 3 of 5 words, then reload
        pulse_start();
        exp_q.push_back({32'd0, 16'h1111});
        exp_q.push_back({32'd1, 16'h2222});
        exp_q.push_back({32'd2, 16'h3333});
        send_byte(8'h00, 0);
        send_byte(8'h05, 0);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h33, 0);
        repeat (2) @(negedge clk);
        check("t5_words3", wl0, 3);
        check("t5_state", st0, 3);
        check_writes("t5_wr");
        rst = 1'b1;
        @(negedge clk);
        check_reset("t5_rst");
        rst = 1'b0;
        pulse_start();
        exp_q.push_back({32'd0, 16'h5555});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 0);
        send_byte(8'h55, 0);
        wait_done("t5_done", 5);
        check_writes("t5_wr2");
        check("t5_cpu_rel", cpu0, 0);

        // 6) start while in DATA_HI is ignored
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        pulse_start();
        check("t6_state", st0, 3);
        check("t6_busy", busy0, 1);
        exp_q.push_back({32'd0, 16'h9ABC});
        send_byte(8'h9A, 0);
        send_byte(8'hBC, 0);
        wait_done("t6_done", 6);
        check_writes("t6_wr");
        check("t6_words", wl0, 1);
        check("t6_cpu_rel", cpu0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
